// File: rtl/div_repeated_sub_if.sv
// Handshake/data bundle for div_repeated_sub.
//   start     : request a division; data_in carries the dividend in that cycle
//   data_in   : dividend in the start cycle, divisor in the following cycle
//   busy      : operation in progress (LDB or CALC)
//   done      : one-cycle pulse; results valid in this cycle
//   quotient  : working quotient register
//   remainder : working remainder register
//   div_zero  : divisor was zero; valid with done
//   abort     : only present when DIV_ABORT_EN is defined; cancels a running operation
interface div_repeated_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;
`ifdef DIV_ABORT_EN
  logic             abort;

  modport master (
    output start, data_in, abort,
    input  busy, done, quotient, remainder, div_zero
  );
  modport slave (
    input  start, data_in, abort,
    output busy, done, quotient, remainder, div_zero
  );
`else
  modport master (
    output start, data_in,
    input  busy, done, quotient, remainder, div_zero
  );
  modport slave (
    input  start, data_in,
    output busy, done, quotient, remainder, div_zero
  );
`endif
endinterface

// File: rtl/div_repeated_sub.sv
// Unsigned divider by repeated subtraction (controller and datapath in one block).
// The dividend arrives with start, the divisor on the next cycle, both on data_in.
// Each CALC cycle subtracts the divisor once from the remainder and bumps the
// quotient; a zero divisor sets div_zero and returns an all-ones quotient.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : div_repeated_sub_if slave modport (start, data_in, busy, done,
//           quotient, remainder, div_zero, and abort when enabled)
// Optional feature: define DIV_ABORT_EN to add bus.abort, which returns a running
// operation (LDB/CALC) to IDLE with all working registers cleared and no done pulse.
module div_repeated_sub #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  div_repeated_sub_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LDB  = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] r, r_d;
  logic [WIDTH-1:0] d, d_d;
  logic [WIDTH-1:0] q, q_d;
  logic             dz, dz_d;

  // Extra top bit is the borrow: clear means R >= D.
  logic [WIDTH:0]   diff;
  logic             r_ge_d;

  assign diff   = {1'b0, r} - {1'b0, d};
  assign r_ge_d = ~diff[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      r     <= '0;
      d     <= '0;
      q     <= '0;
      dz    <= 1'b0;
    end else begin
      state <= state_d;
      r     <= r_d;
      d     <= d_d;
      q     <= q_d;
      dz    <= dz_d;
    end
  end

  always_comb begin
    state_d = state;
    r_d     = r;
    d_d     = d;
    q_d     = q;
    dz_d    = dz;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          r_d     = bus.data_in;
          q_d     = '0;
          dz_d    = 1'b0;
          state_d = S_LDB;
        end
      end
      S_LDB: begin
        d_d     = bus.data_in;
        state_d = S_CALC;
      end
      S_CALC: begin
        if (d == '0) begin
          dz_d    = 1'b1;
          q_d     = '1;
          state_d = S_DONE;
        end else if (r_ge_d) begin
          r_d = diff[WIDTH-1:0];
          q_d = q + WIDTH'(1);
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef DIV_ABORT_EN
    // Overrides every CALC decision above; ignored in IDLE and DONE.
    if (bus.abort && (state == S_LDB || state == S_CALC)) begin
      state_d = S_IDLE;
      r_d     = '0;
      d_d     = '0;
      q_d     = '0;
      dz_d    = 1'b0;
    end
`endif
  end

  assign bus.busy      = (state == S_LDB) || (state == S_CALC);
  assign bus.done      = (state == S_DONE);
  assign bus.quotient  = q;
  assign bus.remainder = r;
  assign bus.div_zero  = dz;

endmodule
